// File: rtl/ciq_issue_select.sv
// ============================================================================
//  Module   : ciq_issue_select
//  Purpose  : CIQ issue controller - occupancy, wakeup, dual oldest-ready pick
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ciq_issue_select #(
    parameter int DECODE_NUM = 4,
    parameter int CIQ_DEPTH  = 16,
    parameter int TAG_W      = 6,
    parameter int WB_NUM     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [DECODE_NUM-1:0]         alloc_en,
    input  logic [4*DECODE_NUM-1:0]       alloc_addr,
    input  logic [2*TAG_W*DECODE_NUM-1:0] alloc_tag,
    input  logic [2*DECODE_NUM-1:0]       alloc_rdy,
    input  logic [WB_NUM-1:0]             wb_valid,
    input  logic [TAG_W*WB_NUM-1:0]       wb_tag,
    output logic [1:0]                    issue_valid,
    output logic [7:0]                    issue_addr,
    input  logic [1:0]                    issue_ack,
    output logic [CIQ_DEPTH-1:0]          ciq_free,
    output logic                          alloc_err
);

    localparam int ADDR_W = 4;

    logic [CIQ_DEPTH-1:0] valid_q, valid_d, rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic [TAG_W-1:0]     tag0_q [CIQ_DEPTH];
    logic [TAG_W-1:0]     tag0_d [CIQ_DEPTH];
    logic [TAG_W-1:0]     tag1_q [CIQ_DEPTH];
    logic [TAG_W-1:0]     tag1_d [CIQ_DEPTH];
    logic [CIQ_DEPTH-1:0] older_q [CIQ_DEPTH];
    logic [CIQ_DEPTH-1:0] older_d [CIQ_DEPTH];
    logic                 alloc_err_q;

    logic [CIQ_DEPTH-1:0]  wake0, wake1, elig, elig1, sel0, sel1, rel, new_mask;
    logic [ADDR_W-1:0]     lane_addr [DECODE_NUM];
    logic [TAG_W-1:0]      lane_t0   [DECODE_NUM];
    logic [TAG_W-1:0]      lane_t1   [DECODE_NUM];
    logic [DECODE_NUM-1:0] lane_r0, lane_r1, lane_win;
    logic [ADDR_W-1:0]     addr0, addr1;
    logic                  alloc_fault;

    function automatic logic wb_hit(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WB_NUM; w++)
            if (wb_valid[w] && (wb_tag[w*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        return hit;
    endfunction

    for (genvar gi = 0; gi < CIQ_DEPTH; gi++) begin : g_entry
        assign wake0[gi] = valid_q[gi] & wb_hit(tag0_q[gi]);
        assign wake1[gi] = valid_q[gi] & wb_hit(tag1_q[gi]);
    end

    for (genvar gk = 0; gk < DECODE_NUM; gk++) begin : g_lane
        assign lane_addr[gk] = alloc_addr[4*gk +: 4];
        assign lane_t0[gk]   = alloc_tag[2*TAG_W*gk +: TAG_W];
        assign lane_t1[gk]   = alloc_tag[2*TAG_W*gk + TAG_W +: TAG_W];
        assign lane_r0[gk]   = alloc_rdy[2*gk]   | wb_hit(lane_t0[gk]);
        assign lane_r1[gk]   = alloc_rdy[2*gk+1] | wb_hit(lane_t1[gk]);
    end

    // A lane wins only if its slot is free and no higher lane claims the same slot.
    always_comb begin
        lane_win = '0;
        for (int k = 0; k < DECODE_NUM; k++) begin
            if (alloc_en[k]) begin
                lane_win[k] = ~valid_q[lane_addr[k]];
                for (int j = k + 1; j < DECODE_NUM; j++)
                    if (alloc_en[j] && (lane_addr[j] == lane_addr[k])) lane_win[k] = 1'b0;
            end
        end
    end
    assign alloc_fault = |(alloc_en & ~lane_win);

    assign elig = valid_q & rdy0_q & rdy1_q;

    always_comb begin
        sel0 = '0;
        for (int i = 0; i < CIQ_DEPTH; i++)
            if (elig[i] && ((elig & older_q[i]) == '0)) sel0[i] = 1'b1;
    end

    assign elig1 = elig & ~sel0;

    always_comb begin
        sel1 = '0;
        for (int i = 0; i < CIQ_DEPTH; i++)
            if (elig1[i] && ((elig1 & older_q[i]) == '0)) sel1[i] = 1'b1;
    end

    always_comb begin
        addr0 = '0;
        addr1 = '0;
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            if (sel0[i]) addr0 = ADDR_W'(i);
            if (sel1[i]) addr1 = ADDR_W'(i);
        end
    end

    assign issue_valid = {|sel1, |sel0};
    assign issue_addr  = {addr1, addr0};
    assign rel         = (issue_ack[0] ? sel0 : '0) | (issue_ack[1] ? sel1 : '0);
    assign ciq_free    = ~valid_q;
    assign alloc_err   = alloc_err_q;

    always_comb begin
        valid_d  = valid_q & ~rel;
        rdy0_d   = (rdy0_q | wake0) & ~rel;
        rdy1_d   = (rdy1_q | wake1) & ~rel;
        tag0_d   = tag0_q;
        tag1_d   = tag1_q;
        older_d  = older_q;
        new_mask = '0;
        for (int k = 0; k < DECODE_NUM; k++) begin
            if (lane_win[k]) begin
                valid_d[lane_addr[k]] = 1'b1;
                tag0_d[lane_addr[k]]  = lane_t0[k];
                tag1_d[lane_addr[k]]  = lane_t1[k];
                rdy0_d[lane_addr[k]]  = lane_r0[k];
                rdy1_d[lane_addr[k]]  = lane_r1[k];
                // The new entry is youngest: drop stale column bits left by a prior occupant.
                for (int i = 0; i < CIQ_DEPTH; i++) older_d[i][lane_addr[k]] = 1'b0;
                older_d[lane_addr[k]]  = valid_q | new_mask;
                new_mask[lane_addr[k]] = 1'b1;
            end
        end
        if (flush) begin
            valid_d = '0;
            rdy0_d  = '0;
            rdy1_d  = '0;
            for (int i = 0; i < CIQ_DEPTH; i++) older_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            rdy0_q      <= '0;
            rdy1_q      <= '0;
            alloc_err_q <= 1'b0;
            for (int i = 0; i < CIQ_DEPTH; i++) begin
                tag0_q[i]  <= '0;
                tag1_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            rdy0_q      <= rdy0_d;
            rdy1_q      <= rdy1_d;
            alloc_err_q <= alloc_err_q | alloc_fault;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
            older_q     <= older_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ciq_issue_select.sv
// ============================================================================
//  Module   : tb_ciq_issue_select
//  Purpose  : Directed self-checking bench for ciq_issue_select
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ciq_issue_select;

    localparam int DECODE_NUM = 4;
    localparam int CIQ_DEPTH  = 16;
    localparam int TAG_W      = 6;
    localparam int WB_NUM     = 2;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          flush;
    logic [DECODE_NUM-1:0]         alloc_en;
    logic [4*DECODE_NUM-1:0]       alloc_addr;
    logic [2*TAG_W*DECODE_NUM-1:0] alloc_tag;
    logic [2*DECODE_NUM-1:0]       alloc_rdy;
    logic [WB_NUM-1:0]             wb_valid;
    logic [TAG_W*WB_NUM-1:0]       wb_tag;
    logic [1:0]                    issue_valid;
    logic [7:0]                    issue_addr;
    logic [1:0]                    issue_ack;
    logic [CIQ_DEPTH-1:0]          ciq_free;
    logic                          alloc_err;

    int n_chk  = 0;
    int n_fail = 0;

    ciq_issue_select #(
        .DECODE_NUM (DECODE_NUM),
        .CIQ_DEPTH  (CIQ_DEPTH),
        .TAG_W      (TAG_W),
        .WB_NUM     (WB_NUM)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .alloc_tag   (alloc_tag),
        .alloc_rdy   (alloc_rdy),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ack   (issue_ack),
        .ciq_free    (ciq_free),
        .alloc_err   (alloc_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush      = 1'b0;
        alloc_en   = '0;
        alloc_addr = '0;
        alloc_tag  = '0;
        alloc_rdy  = '0;
        wb_valid   = '0;
        wb_tag     = '0;
        issue_ack  = '0;
    endtask

    task automatic set_alloc(input int k, input int addr, input int t0, input int t1,
                             input bit r0, input bit r1);
        logic [3:0]       a;
        logic [TAG_W-1:0] s0, s1;
        a  = addr[3:0];
        s0 = t0[TAG_W-1:0];
        s1 = t1[TAG_W-1:0];
        alloc_en[k]                          = 1'b1;
        alloc_addr[4*k +: 4]                 = a;
        alloc_tag[2*TAG_W*k +: TAG_W]        = s0;
        alloc_tag[2*TAG_W*k + TAG_W +: TAG_W] = s1;
        alloc_rdy[2*k]                       = r0;
        alloc_rdy[2*k+1]                     = r1;
    endtask

    task automatic set_wb(input int w, input int tag);
        logic [TAG_W-1:0] t;
        t = tag[TAG_W-1:0];
        wb_valid[w]              = 1'b1;
        wb_tag[w*TAG_W +: TAG_W] = t;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step();
        check("reset_free",  32'(ciq_free),    32'hFFFF);
        check("reset_valid", 32'(issue_valid), 32'h0);
        check("reset_addr",  32'(issue_addr),  32'h0);
        check("reset_err",   32'(alloc_err),   32'h0);
        rst_n = 1'b1;
        step();

        // Age order: lanes 0..3 -> slots 3,5,0,9, all ready, acks held.
        set_alloc(0, 3, 1, 2, 1, 1);
        set_alloc(1, 5, 1, 2, 1, 1);
        set_alloc(2, 0, 1, 2, 1, 1);
        set_alloc(3, 9, 1, 2, 1, 1);
        issue_ack = 2'b11;
        step();
        alloc_en = '0;
        check("age_free1",  32'(ciq_free),    32'hFDD6);
        check("age_valid1", 32'(issue_valid), 32'h3);
        check("age_addr1",  32'(issue_addr),  32'h53);
        step();
        check("age_valid2", 32'(issue_valid), 32'h3);
        check("age_addr2",  32'(issue_addr),  32'h90);
        step();
        check("age_free3",  32'(ciq_free),    32'hFFFF);
        check("age_valid3", 32'(issue_valid), 32'h0);
        check("age_addr3",  32'(issue_addr),  32'h0);
        idle();

        // Wakeup: slot 2 waits on tag 12.
        set_alloc(0, 2, 7, 12, 1, 0);
        step();
        idle();
        check("wk_before", 32'(issue_valid), 32'h0);
        set_wb(0, 12);
        check("wk_same_cycle", 32'(issue_valid), 32'h0);
        step();
        idle();
        check("wk_valid", 32'(issue_valid), 32'h1);
        check("wk_addr",  32'(issue_addr),  32'h02);
        issue_ack = 2'b01;
        step();
        idle();
        check("wk_free", 32'(ciq_free), 32'hFFFF);

        // Same-cycle wakeup at allocation.
        set_alloc(0, 7, 20, 21, 0, 1);
        set_wb(1, 20);
        step();
        idle();
        check("wk_alloc_valid", 32'(issue_valid), 32'h1);
        check("wk_alloc_addr",  32'(issue_addr),  32'h07);
        issue_ack = 2'b01;
        step();
        idle();
        check("wk_alloc_free", 32'(ciq_free), 32'hFFFF);

        // Back-pressure: older slot 11 waits on tag 40, slot 4 ready and unacked.
        set_alloc(0, 11, 40, 0, 0, 1);
        step();
        idle();
        set_alloc(0, 4, 1, 1, 1, 1);
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", 32'(issue_valid), 32'h1);
            check("bp_addr",  32'(issue_addr),  32'h04);
            check("bp_free4", 32'(ciq_free[4]), 32'h0);
            step();
        end
        set_wb(0, 40);
        step();
        idle();
        check("bp_reorder_valid", 32'(issue_valid), 32'h3);
        check("bp_reorder_addr",  32'(issue_addr),  32'h4B);
        issue_ack = 2'b11;
        step();
        idle();
        check("bp_free", 32'(ciq_free), 32'hFFFF);

        // Illegal allocation into occupied slot 6.
        set_alloc(0, 6, 5, 9, 1, 0);
        step();
        idle();
        check("ill_err0", 32'(alloc_err), 32'h0);
        set_alloc(0, 6, 1, 1, 1, 1);
        step();
        idle();
        check("ill_err1",      32'(alloc_err),   32'h1);
        check("ill_unchanged", 32'(issue_valid), 32'h0);
        step();
        check("ill_sticky", 32'(alloc_err), 32'h1);
        set_wb(0, 9);
        step();
        idle();
        check("ill_wk_addr", 32'(issue_addr), 32'h06);
        issue_ack = 2'b01;
        set_alloc(0, 6, 1, 1, 1, 1);
        step();
        idle();
        check("ill_ack_free", 32'(ciq_free), 32'hFFFF);

        // Asynchronous reset with five valid entries.
        set_alloc(0, 0, 1, 1, 1, 1);
        set_alloc(1, 1, 1, 1, 1, 1);
        set_alloc(2, 2, 1, 1, 1, 1);
        set_alloc(3, 3, 1, 1, 1, 1);
        step();
        idle();
        set_alloc(0, 4, 1, 1, 1, 1);
        step();
        idle();
        check("rst_pre_free", 32'(ciq_free), 32'hFFE0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_free",  32'(ciq_free),    32'hFFFF);
        check("rst_async_valid", 32'(issue_valid), 32'h0);
        check("rst_async_err",   32'(alloc_err),   32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Allocation into a slot acked in the same cycle is still illegal.
        set_alloc(0, 6, 1, 1, 1, 1);
        step();
        idle();
        check("ackalloc_addr", 32'(issue_addr), 32'h06);
        check("ackalloc_err0", 32'(alloc_err),  32'h0);
        issue_ack = 2'b01;
        set_alloc(0, 6, 1, 1, 1, 1);
        step();
        idle();
        check("ackalloc_err1", 32'(alloc_err), 32'h1);
        check("ackalloc_free", 32'(ciq_free),  32'hFFFF);

        // Two lanes on one slot: the higher lane (not ready) wins.
        set_alloc(0, 12, 1, 1, 1, 1);
        set_alloc(1, 12, 50, 1, 0, 1);
        step();
        idle();
        check("dup_free",  32'(ciq_free),    32'hEFFF);
        check("dup_valid", 32'(issue_valid), 32'h0);

        // Fill the queue, then flush with a colliding allocation and acks.
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) set_alloc(k, 4*c + k, 1, 1, 1, 1);
            step();
            idle();
        end
        check("full_free", 32'(ciq_free), 32'h0000);
        flush     = 1'b1;
        issue_ack = 2'b11;
        set_alloc(0, 0, 1, 1, 1, 1);
        step();
        idle();
        check("flush_free",  32'(ciq_free),    32'hFFFF);
        check("flush_valid", 32'(issue_valid), 32'h0);
        check("flush_err",   32'(alloc_err),   32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ciq_issue_select.md
# ciq_issue_select

Issue-side controller of the 16-entry compressed issue queue (CIQ): the consumer of the slot addresses that the allocation logic hands out. It records which slots are occupied, tracks operand readiness through the writeback wakeup bus, and picks up to two oldest-ready entries per cycle for the functional units. It frees each slot on issue handshake and drives the registered `ciq_free` vector that allocation consumes. Payload storage is external and indexed by the same 4-bit slot address.

## Interface
- `DECODE_NUM`, 4: allocation lanes per cycle.
- `CIQ_DEPTH`, 16: queue entries; slot address width is fixed at 4.
- `TAG_W`, 6: physical-register tag width.
- `WB_NUM`, 2: wakeup (writeback) lanes per cycle.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of all entries.
- `alloc_en` in DECODE_NUM: per-lane write request.
- `alloc_addr` in 4*DECODE_NUM: slot address per lane; lane k is bits [4k+3:4k].
- `alloc_tag` in 2*TAG_W*DECODE_NUM: source tags src0 and src1 per lane; lane k is bits [2*TAG_W*k +: 2*TAG_W], with src0 in the low half.
- `alloc_rdy` in 2*DECODE_NUM: source-already-ready bits per lane; lane k is bits {src1,src0} = [2k+1:2k].
- `wb_valid` in WB_NUM: wakeup valid per lane.
- `wb_tag` in TAG_W*WB_NUM: wakeup tag per lane.
- `issue_valid` out 2: issue lane has a selected entry.
- `issue_addr` out 8: slot address per issue lane; lane 0 is bits [3:0] and is always the older selection.
- `issue_ack` in 2: FU accepts the issue lane this cycle.
- `ciq_free` out CIQ_DEPTH: registered free flags, equal to ~valid.
- `alloc_err` out 1: sticky flag, set when an allocation targets an occupied slot.

## Operation
- Per-entry state: `valid`, `rdy0`, `rdy1`, `tag0`, `tag1`, and an age-matrix row, where `older[i][j]`=1 means entry j is older than entry i.
- **Allocation.** For each lane k with `alloc_en[k]`, where slot a=`alloc_addr[k]` has `ciq_free[a]`=1:
  - set `valid[a]`;
  - load the tags;
  - set rdy = `alloc_rdy | (wb_valid & tag match)` for the same-cycle wakeup.
  - The age row of a is set to 1 for every currently valid entry and for every slot allocated this cycle on a lane below k.
- **Illegal allocation.** Allocation to a slot with `ciq_free[a]`=0 is ignored: no state change, and `alloc_err` is set until reset. This includes a slot being released in the same cycle, because `ciq_free` is the registered pre-release value. Two lanes targeting the same slot is illegal; the higher lane wins, and `alloc_err` is set.
- **Wakeup.** Every cycle, for each valid entry and each lane w with `wb_valid[w]`, `tag0==wb_tag[w]` sets `rdy0`; likewise for `tag1`/`rdy1`. Ready bits never clear while an entry is valid.
- **Eligibility.** E[i] = `valid & rdy0 & rdy1`, from registers only. Issue logic is combinational from state.
- **Lane 0** selects the eligible i with no eligible j where `older[i][j]`=1.
- **Lane 1** applies the same rule over E with lane 0's selection removed.
- `issue_valid[n]`=0 when no candidate exists; `issue_addr[n]` is then 0.
- Selections are not held across cycles. When `issue_ack[n]` is low, the consumer re-samples next cycle, and the selected address may differ.
- **Release.** `issue_valid[n] & issue_ack[n]` clears `valid`, `rdy0` and `rdy1` of that slot at the edge. `issue_ack` without `issue_valid` is ignored.
- **Flush.** Clears all `valid`, `rdy` and age bits at the edge and overrides same-cycle allocation, wakeup and release. `alloc_err` is unaffected.

## Timing
- **Reset.** All `valid`/`rdy`/age bits are 0. Outputs: `ciq_free`=all ones, `issue_valid`=0, `issue_addr`=0, `alloc_err`=0.
- **Allocate to issue.** An entry allocated with both sources ready at edge N is selectable in cycle N (after the edge) and leaves at edge N+1 if acked.
- **Wakeup to issue.** A wakeup sampled at edge N makes the entry selectable in cycle N.
- **Free visibility.** A slot released at edge N shows `ciq_free`=1 from cycle N, so it is allocatable at edge N+1.
- **Throughput.** Up to DECODE_NUM allocations and 2 releases per cycle. A full queue (`ciq_free`=0) is legal; with `alloc_en` held, every allocation is illegal.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-operation with 5 valid entries -> `ciq_free`=16'hFFFF, `issue_valid`=0, `alloc_err`=0 immediately, asynchronously.
- **Age order.** Allocate lanes 0..3 to slots 3,5,0,9, all ready, with acks held high -> issue {3,5} in the first cycle and {0,9} in the next; `ciq_free` returns to FFFF.
- **Wakeup.** Allocate slot 2 (tag0=7 ready, tag1=12 not ready), then pulse `wb_tag`=12 -> `issue_valid[0]`=1, `addr`=2 in the cycle after the wakeup edge, not earlier. A same-cycle wakeup at allocation gives issue in the next cycle.
- **Back-pressure.** Keep `issue_ack`=0 for 3 cycles with slot 4 ready -> slot 4 stays selected and valid. Then allocate older-eligible ordering changes and check that the selection updates to the oldest.
- **Illegal allocation.** Allocate into occupied slot 6 -> entry 6 is unchanged and `alloc_err`=1 sticky. Allocating into slot 6 in the same cycle it is acked also sets `alloc_err`.
- **Full and flush.** Fill all 16 slots -> `ciq_free`=0. Flush together with an allocation and an ack -> `ciq_free`=FFFF and `issue_valid`=0 the next cycle.
